// File: rtl/loba_pkg.sv
// Shared defaults and helpers for the leading-one-bit truncating multiplier.
// The helper computes the truncation shift from a leading-one position.
package loba_pkg;

  localparam int W_DEF  = 16;
  localparam int P_DEF  = 4;
  localparam int SW_DEF = $clog2(W_DEF);
  localparam int PW_DEF = 2 * W_DEF;

  // Number of low bits dropped so that exactly p bits remain from the leading one down.
  function automatic int unsigned lob_shift(input int unsigned k, input int unsigned p);
    return (k + 1 > p) ? (k + 1 - p) : 0;
  endfunction

endpackage

// File: rtl/loba_lob_pos.sv
// Combinational priority encoder: index of the highest set bit plus a nonzero flag.
// An all-zero input reports position 0 with nz=0.
module loba_lob_pos #(
  parameter int W  = 16,
  parameter int SW = 4
) (
  input  logic [W-1:0]  x,
  output logic [SW-1:0] pos,
  output logic          nz
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) pos = SW'(i);
    end
  end

  assign nz = |x;

endmodule

// File: rtl/loba_mult_pipe.sv
// Three-stage approximate unsigned multiplier: each operand is truncated to P bits
// below its leading one, the mantissas are multiplied exactly and shifted back up.
module loba_mult_pipe
  import loba_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int P = P_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           out_zero
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = 2 * W;

  logic          advance;
  logic          in_fire;

  logic [SW-1:0] ka_c, kb_c;
  logic          nza_c, nzb_c;
  logic [SW-1:0] sa_c, sb_c;

  logic          v1;
  logic [W-1:0]  a1, b1;
  logic [SW-1:0] ka1, kb1;
  logic [SW-1:0] sa1, sb1;

  logic          v2;
  logic [P-1:0]  ah2, bh2;
  logic [SW:0]   ssum2;
  logic          zero2;

  logic [P-1:0]  ah_c, bh_c;
  logic [SW:0]   ssum_c;
  logic          zero_c;
  logic [PW-1:0] prod_c;

  // Whole pipeline moves as one unit whenever the output slot is free or being drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign in_fire  = in_valid && advance;

  loba_lob_pos #(.W(W), .SW(SW)) u_lob_a (.x(in_a), .pos(ka_c), .nz(nza_c));
  loba_lob_pos #(.W(W), .SW(SW)) u_lob_b (.x(in_b), .pos(kb_c), .nz(nzb_c));

  assign sa_c = nza_c ? SW'(lob_shift(32'(ka_c), P)) : '0;
  assign sb_c = nzb_c ? SW'(lob_shift(32'(kb_c), P)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      ka1 <= '0;
      kb1 <= '0;
      sa1 <= '0;
      sb1 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1  <= in_a;
        b1  <= in_b;
        ka1 <= ka_c;
        kb1 <= kb_c;
        sa1 <= sa_c;
        sb1 <= sb_c;
      end
    end
  end

  // k=0 is ambiguous between x=1 and x=0, so bit 0 settles it.
  always_comb begin
    ah_c   = P'(a1 >> sa1);
    bh_c   = P'(b1 >> sb1);
    ssum_c = (SW+1)'(sa1) + (SW+1)'(sb1);
    zero_c = ((ka1 == '0) && !a1[0]) || ((kb1 == '0) && !b1[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      ah2   <= '0;
      bh2   <= '0;
      ssum2 <= '0;
      zero2 <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
      if (v1) begin
        ah2   <= ah_c;
        bh2   <= bh_c;
        ssum2 <= ssum_c;
        zero2 <= zero_c;
      end
    end
  end

  // Mantissa product fits in 2P bits; shift of at most 2(W-P) keeps it within 2W.
  always_comb begin
    prod_c = (PW'(ah2) * PW'(bh2)) << ssum2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_zero    <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        out_product <= zero2 ? '0 : prod_c;
        out_zero    <= zero2;
      end
    end
  end

endmodule

// File: tb/tb_loba_mult_pipe.sv
// Self-checking bench for loba_mult_pipe: vector table, hand sequences for latency,
// stall and mid-flight reset, plus a randomised handshake run, all via a scoreboard.
module tb_loba_mult_pipe;

  localparam int W = 16;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic          out_zero;

  loba_mult_pipe #(.W(W), .P(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           z;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic           z;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic done_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ka, kb, sa, sb_s;
    logic [2*W-1:0] ah, bh;
    if (a == 0 || b == 0) return '0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    sa   = (ka >= P - 1) ? ka - P + 1 : 0;
    sb_s = (kb >= P - 1) ? kb - P + 1 : 0;
    ah = (2*W)'(a >> sa);
    bh = (2*W)'(b >> sb_s);
    return (ah * bh) << (sa + sb_s);
  endfunction

  // Monitor: pops on output transfers, checks hold-stability across stalls.
  logic           prev_stall = 1'b0;
  logic [2*W-1:0] prev_p = '0;
  logic           prev_z = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_product_held", out_product, prev_p);
        check("stall_zero_held", 32'(out_zero), 32'(prev_z));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got product %h with no pending result", out_product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_product", out_product, e.p);
          check("out_zero", 32'(out_zero), 32'(e.z));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p = out_product;
      prev_z = out_zero;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the pair.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] p, input logic z);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{p, z});
        @(posedge clk);
        #1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: got in_ready low for 50 cycles, expected accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{16'h00F0, 16'h0003, 32'h000002D0, 1'b0};
    vt[1] = '{16'hFFFF, 16'hFFFF, 32'hE1000000, 1'b0};
    vt[2] = '{16'h1234, 16'h0010, 32'h00012000, 1'b0};
    vt[3] = '{16'h0000, 16'hBEEF, 32'h00000000, 1'b1};
    vt[4] = '{16'h0001, 16'h0001, 32'h00000001, 1'b0};
    vt[5] = '{16'hBEEF, 16'h0000, 32'h00000000, 1'b1};
    vt[6] = '{16'h000F, 16'h000F, 32'h000000E1, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 32'h40000000, 1'b0};

    // Reset held with a valid pair already presented.
    in_valid = 1'b1;
    in_a = 16'h00F0;
    in_b = 16'h0003;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_product", out_product, 32'd0);
    check("reset_out_zero", 32'(out_zero), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{32'h000002D0, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      check($sformatf("latency_cycle%0d", cyc), 32'(out_valid), (cyc == 3) ? 32'd1 : 32'd0);
    end
    drain();

    // Directed vector table, back-to-back.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].p, vt[i].z);
    in_valid = 1'b0;
    drain();

    // Eight back-to-back pairs with the output stalled in cycles 4-6.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom());
          rb = W'($urandom());
          send(ra, rb, model(ra, rb), (ra == 0) || (rb == 0));
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 4 && c <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random gaps on both sides, including zero and small operands.
    @(posedge clk);
    #1;
    done_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom());
          rb = W'($urandom());
          if ($urandom_range(0, 7) == 0) ra = '0;
          if ($urandom_range(0, 7) == 0) rb = W'($urandom_range(0, 15));
          send(ra, rb, model(ra, rb), (ra == 0) || (rb == 0));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while three results are in flight.
    @(posedge clk);
    #1;
    send(16'h0123, 16'h0456, model(16'h0123, 16'h0456), 1'b0);
    send(16'h0F00, 16'h00F0, model(16'h0F00, 16'h00F0), 1'b0);
    send(16'h7777, 16'h0002, model(16'h7777, 16'h0002), 1'b0);
    in_valid = 1'b0;
    check("flight_valid_before_reset", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("flight_reset_out_valid", 32'(out_valid), 32'd0);
    check("flight_reset_out_product", out_product, 32'd0);
    check("flight_reset_out_zero", 32'(out_zero), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'h0003, 16'h0005, 32'h0000000F, 1'b0);
    in_valid = 1'b0;
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
